// File: rtl/idu_pkg.sv
// Shared definitions for the decode-stage hazard unit: default sizes,
// forwarding port indices and the debug hazard-reason encoding.
package idu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int RIDX_W_DEF  = 5;
  localparam int CNT_W_DEF   = 2;
  localparam int NUM_FWD_DEF = 3;

  localparam int REG_ZERO     = 0;
  localparam int FWD_YOUNGEST = 0;
  localparam int FWD_WB       = NUM_FWD_DEF - 1;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_RS1  = 2'd1,
    HZ_RS2  = 2'd2,
    HZ_WAW  = 2'd3
  } hz_reason_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/idu_scoreboard_if.sv
// Decode/forwarding/writeback/issue signal bundle of the hazard unit.
// The slave modport is the scoreboard side, master is its environment.
interface idu_scoreboard_if #(
  parameter int XLEN    = 32,
  parameter int RIDX_W  = 5,
  parameter int NUM_FWD = 3
);

  logic                      in_valid;
  logic                      in_ready;
  logic [RIDX_W-1:0]         in_rs1;
  logic [RIDX_W-1:0]         in_rs2;
  logic                      in_rs1_used;
  logic                      in_rs2_used;
  logic [RIDX_W-1:0]         in_rd;
  logic                      in_rd_we;
  logic [XLEN-1:0]           rsa;
  logic [XLEN-1:0]           rsb;
  logic [NUM_FWD-1:0]        fwd_busy;
  logic [NUM_FWD-1:0]        fwd_ok;
  logic [NUM_FWD*RIDX_W-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      wb_valid;
  logic [RIDX_W-1:0]         wb_rd;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [XLEN-1:0]           issue_src1;
  logic [XLEN-1:0]           issue_src2;
  logic [RIDX_W-1:0]         issue_rd;
  logic                      issue_rd_we;
  logic [31:0]               stall_cycles;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_rd, in_rd_we,
    output rsa, rsb, fwd_busy, fwd_ok, fwd_rd, fwd_data, wb_valid, wb_rd, flush,
    output issue_ready,
    input  in_ready, issue_valid, issue_src1, issue_src2, issue_rd, issue_rd_we,
    input  stall_cycles
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_rd, in_rd_we,
    input  rsa, rsb, fwd_busy, fwd_ok, fwd_rd, fwd_data, wb_valid, wb_rd, flush,
    input  issue_ready,
    output in_ready, issue_valid, issue_src1, issue_src2, issue_rd, issue_rd_we,
    output stall_cycles
  );

endinterface

// File: rtl/fwd_select.sv
// Priority scan of the forwarding ports for one source operand.
// Port 0 is the youngest stage and wins over every older match.
module fwd_select #(
  parameter int XLEN    = 32,
  parameter int RIDX_W  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [RIDX_W-1:0]         src,
  input  logic [NUM_FWD-1:0]        fwd_busy,
  input  logic [NUM_FWD-1:0]        fwd_ok,
  input  logic [NUM_FWD*RIDX_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      hit,
  output logic                      ok,
  output logic [XLEN-1:0]           data
);

  logic match_s;

  // Walk from the oldest port down so the youngest match is written last.
  always_comb begin
    hit     = 1'b0;
    ok      = 1'b0;
    data    = '0;
    match_s = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      match_s = fwd_busy[i] && (fwd_rd[i*RIDX_W +: RIDX_W] == src);
      hit     = match_s ? 1'b1 : hit;
      ok      = match_s ? fwd_ok[i] : ok;
      data    = match_s ? fwd_data[i*XLEN +: XLEN] : data;
    end
  end

endmodule

// File: rtl/idu_scoreboard_chk.sv
// Protocol checks for the hazard unit: issue payload holds under
// backpressure and no writer count is retired below zero.
module idu_scoreboard_chk #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input logic              clk,
  input logic              rst,
  input logic              issue_valid,
  input logic              issue_ready,
  input logic              flush,
  input logic [XLEN-1:0]   issue_src1,
  input logic [XLEN-1:0]   issue_src2,
  input logic [RIDX_W-1:0] issue_rd,
  input logic              issue_rd_we,
  input logic              cnt_underflow
);

  a_issue_stable: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && !issue_ready && !flush) |=>
      (issue_valid && $stable(issue_src1) && $stable(issue_src2) &&
       $stable(issue_rd) && $stable(issue_rd_we)))
    else $error("issue payload changed while stalled");

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !cnt_underflow)
    else $error("writeback retired a register with no writer in flight");

endmodule

// File: rtl/idu_scoreboard.sv
// Decode-stage hazard unit: counted per-register writer scoreboard,
// priority operand forwarding and the decode->issue pipeline register.
module idu_scoreboard
  import idu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int RIDX_W  = RIDX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input logic             clk,
  input logic             rst,
  idu_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  cnt_r [NREGS];
  logic [NREGS-1:0]  inc_s;
  logic [NREGS-1:0]  dec_s;
  logic [NREGS-1:0]  underflow_vec_s;
  logic              cnt_underflow_s;

  logic              hit1_s, ok1_s, hit2_s, ok2_s;
  logic [XLEN-1:0]   fdata1_s, fdata2_s;
  logic [CNT_W-1:0]  cnt_rs1_s, cnt_rs2_s, cnt_rd_s;
  logic              haz1_s, haz2_s, waw_s, hazard_s;
  logic [XLEN-1:0]   val1_s, val2_s;
  hz_reason_e        hz_reason_s;

  logic              in_ready_s;
  logic              accept_s;
  logic              issue_fire_s;

  logic              issue_valid_r;
  logic [XLEN-1:0]   issue_src1_r;
  logic [XLEN-1:0]   issue_src2_r;
  logic [RIDX_W-1:0] issue_rd_r;
  logic              issue_rd_we_r;
  logic [31:0]       stall_r;

  // Register x0 never holds a count, so the lookup starts at index 1.
  function automatic logic [CNT_W-1:0] cnt_at(input logic [RIDX_W-1:0] idx);
    logic [CNT_W-1:0] v;
    v = '0;
    for (int r = 1; r < NREGS; r++) begin
      v = (idx == RIDX_W'(r)) ? cnt_r[r] : v;
    end
    return v;
  endfunction

  function automatic void resolve_src(
    input  logic              used,
    input  logic [RIDX_W-1:0] idx,
    input  logic [XLEN-1:0]   rdata,
    input  logic              hit,
    input  logic              ok,
    input  logic [XLEN-1:0]   fdata,
    input  logic [CNT_W-1:0]  cnt,
    output logic              haz,
    output logic [XLEN-1:0]   val
  );
    haz = 1'b0;
    val = rdata;
    if (idx == RIDX_W'(REG_ZERO)) begin
      val = '0;
    end else if (!used) begin
      val = rdata;
    end else if (hit) begin
      haz = !ok;
      val = fdata;
    end else if (cnt != '0) begin
      haz = 1'b1;
    end else begin
      val = rdata;
    end
  endfunction

  fwd_select #(.XLEN(XLEN), .RIDX_W(RIDX_W), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .src      (bus.in_rs1),
    .fwd_busy (bus.fwd_busy),
    .fwd_ok   (bus.fwd_ok),
    .fwd_rd   (bus.fwd_rd),
    .fwd_data (bus.fwd_data),
    .hit      (hit1_s),
    .ok       (ok1_s),
    .data     (fdata1_s)
  );

  fwd_select #(.XLEN(XLEN), .RIDX_W(RIDX_W), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .src      (bus.in_rs2),
    .fwd_busy (bus.fwd_busy),
    .fwd_ok   (bus.fwd_ok),
    .fwd_rd   (bus.fwd_rd),
    .fwd_data (bus.fwd_data),
    .hit      (hit2_s),
    .ok       (ok2_s),
    .data     (fdata2_s)
  );

  // Operand resolution and hazard classification for the decode slot.
  always_comb begin
    cnt_rs1_s = cnt_at(bus.in_rs1);
    cnt_rs2_s = cnt_at(bus.in_rs2);
    cnt_rd_s  = cnt_at(bus.in_rd);
    haz1_s    = 1'b0;
    haz2_s    = 1'b0;
    val1_s    = '0;
    val2_s    = '0;
    resolve_src(bus.in_rs1_used, bus.in_rs1, bus.rsa, hit1_s, ok1_s, fdata1_s,
                cnt_rs1_s, haz1_s, val1_s);
    resolve_src(bus.in_rs2_used, bus.in_rs2, bus.rsb, hit2_s, ok2_s, fdata2_s,
                cnt_rs2_s, haz2_s, val2_s);
    waw_s = bus.in_rd_we && (bus.in_rd != RIDX_W'(REG_ZERO)) && (cnt_rd_s == CNT_MAX);
    if (haz1_s) begin
      hz_reason_s = HZ_RS1;
    end else if (haz2_s) begin
      hz_reason_s = HZ_RS2;
    end else if (waw_s) begin
      hz_reason_s = HZ_WAW;
    end else begin
      hz_reason_s = HZ_NONE;
    end
    hazard_s = (hz_reason_s != HZ_NONE);
  end

  assign in_ready_s   = (!issue_valid_r || bus.issue_ready) && !hazard_s && !bus.flush;
  assign accept_s     = bus.in_valid && in_ready_s;
  // A flushed entry never reaches the EXU, so it is never counted.
  assign issue_fire_s = issue_valid_r && bus.issue_ready && !bus.flush;

  // Per-register increment/decrement requests for the writer counters.
  always_comb begin
    inc_s           = '0;
    dec_s           = '0;
    underflow_vec_s = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc_s[r] = issue_fire_s && issue_rd_we_r && (issue_rd_r == RIDX_W'(r));
      dec_s[r] = bus.wb_valid && (bus.wb_rd == RIDX_W'(r));
      underflow_vec_s[r] = dec_s[r] && !inc_s[r] && (cnt_r[r] == '0);
    end
    cnt_underflow_s = |underflow_vec_s;
  end

  // Writer counters: saturate at both ends, opposite requests cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (inc_s[r] && !dec_s[r] && (cnt_r[r] != CNT_MAX)) begin
          cnt_r[r] <= cnt_r[r] + CNT_W'(1);
        end else if (dec_s[r] && !inc_s[r] && (cnt_r[r] != '0)) begin
          cnt_r[r] <= cnt_r[r] - CNT_W'(1);
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // Issue register: flush wins, then a new accept, then drain on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_r <= 1'b0;
      issue_src1_r  <= '0;
      issue_src2_r  <= '0;
      issue_rd_r    <= '0;
      issue_rd_we_r <= 1'b0;
    end else if (bus.flush) begin
      issue_valid_r <= 1'b0;
    end else if (accept_s) begin
      issue_valid_r <= 1'b1;
      issue_src1_r  <= val1_s;
      issue_src2_r  <= val2_s;
      issue_rd_r    <= bus.in_rd;
      issue_rd_we_r <= bus.in_rd_we;
    end else if (issue_valid_r && bus.issue_ready) begin
      issue_valid_r <= 1'b0;
    end else begin
      issue_valid_r <= issue_valid_r;
    end
  end

  // Stall performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= 32'd0;
    end else if (bus.in_valid && hazard_s && !bus.flush) begin
      stall_r <= sat_inc32(stall_r);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.issue_valid  = issue_valid_r;
  assign bus.issue_src1   = issue_src1_r;
  assign bus.issue_src2   = issue_src2_r;
  assign bus.issue_rd     = issue_rd_r;
  assign bus.issue_rd_we  = issue_rd_we_r;
  assign bus.stall_cycles = stall_r;

  idu_scoreboard_chk #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_chk (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid_r),
    .issue_ready   (bus.issue_ready),
    .flush         (bus.flush),
    .issue_src1    (issue_src1_r),
    .issue_src2    (issue_src2_r),
    .issue_rd      (issue_rd_r),
    .issue_rd_we   (issue_rd_we_r),
    .cnt_underflow (cnt_underflow_s)
  );

endmodule

// File: tb/tb_idu_scoreboard.sv
// Directed bench for idu_scoreboard: table of single-instruction resolve
// vectors followed by hand-written multi-cycle hazard sequences.
module tb_idu_scoreboard;

  localparam int XLEN    = 32;
  localparam int RIDX_W  = 5;
  localparam int NUM_FWD = 3;
  localparam int NV      = 9;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   stall_exp;

  idu_scoreboard_if #(.XLEN(XLEN), .RIDX_W(RIDX_W), .NUM_FWD(NUM_FWD)) bus ();

  idu_scoreboard #(.XLEN(XLEN), .NREGS(32), .RIDX_W(RIDX_W), .CNT_W(2),
                   .NUM_FWD(NUM_FWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  busy;
    logic [2:0]  ok;
    logic [14:0] frd;
    logic        exp_rdy;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t        vecs [NV];
  logic [95:0] fdat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_rs1      = 5'd0;
    bus.in_rs2      = 5'd0;
    bus.in_rs1_used = 1'b0;
    bus.in_rs2_used = 1'b0;
    bus.in_rd       = 5'd0;
    bus.in_rd_we    = 1'b0;
    bus.rsa         = 32'd0;
    bus.rsb         = 32'd0;
    bus.fwd_busy    = 3'b000;
    bus.fwd_ok      = 3'b000;
    bus.fwd_rd      = 15'd0;
    bus.fwd_data    = 96'd0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b1;
  endtask

  task automatic src(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [31:0] a, input logic [31:0] b);
    bus.in_rs1      = rs1;
    bus.in_rs1_used = u1;
    bus.in_rs2      = rs2;
    bus.in_rs2_used = u2;
    bus.rsa         = a;
    bus.rsb         = b;
  endtask

  task automatic dst(input logic [4:0] rd, input logic we);
    bus.in_rd    = rd;
    bus.in_rd_we = we;
  endtask

  function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] busy, input logic [2:0] ok,
                              input logic [14:0] frd, input logic exp_rdy,
                              input logic [31:0] exp1, input logic [31:0] exp2);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.a = a; v.b = b;
    v.busy = busy; v.ok = ok; v.frd = frd;
    v.exp_rdy = exp_rdy; v.exp1 = exp1; v.exp2 = exp2;
    return v;
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    stall_exp = 0;
    fdat      = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    vecs[0] = mk(5'd1, 1'b1, 5'd2, 1'b1, 32'h11, 32'h22, 3'b000, 3'b000, 15'd0,
                 1'b1, 32'h11, 32'h22);
    vecs[1] = mk(5'd0, 1'b1, 5'd3, 1'b0, 32'hAAAA, 32'hBBBB, 3'b000, 3'b000, 15'd0,
                 1'b1, 32'h0, 32'hBBBB);
    vecs[2] = mk(5'd6, 1'b1, 5'd8, 1'b1, 32'h33, 32'h44, 3'b111, 3'b111,
                 {5'd6, 5'd6, 5'd6}, 1'b1, 32'h100, 32'h44);
    vecs[3] = mk(5'd0, 1'b0, 5'd6, 1'b1, 32'h55, 32'h66, 3'b110, 3'b110,
                 {5'd6, 5'd6, 5'd6}, 1'b1, 32'h0, 32'h101);
    vecs[4] = mk(5'd6, 1'b1, 5'd2, 1'b1, 32'h1, 32'h2, 3'b011, 3'b010,
                 {5'd6, 5'd6, 5'd6}, 1'b0, 32'h0, 32'h0);
    vecs[5] = mk(5'd6, 1'b0, 5'd0, 1'b0, 32'h77, 32'h88, 3'b001, 3'b000,
                 {5'd0, 5'd0, 5'd6}, 1'b1, 32'h77, 32'h0);
    vecs[6] = mk(5'd0, 1'b1, 5'd0, 1'b1, 32'h99, 32'h98, 3'b001, 3'b000, 15'd0,
                 1'b1, 32'h0, 32'h0);
    vecs[7] = mk(5'd9, 1'b1, 5'd9, 1'b1, 32'h1, 32'h2, 3'b100, 3'b100,
                 {5'd9, 5'd0, 5'd0}, 1'b1, 32'h102, 32'h102);
    vecs[8] = mk(5'd6, 1'b1, 5'd7, 1'b1, 32'h1, 32'h2, 3'b100, 3'b000,
                 {5'd7, 5'd0, 5'd0}, 1'b0, 32'h0, 32'h0);

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_src1", bus.issue_src1, 32'd0);
    chk("rst_src2", bus.issue_src2, 32'd0);
    chk("rst_rd", 32'(bus.issue_rd), 32'd0);
    chk("rst_rd_we", 32'(bus.issue_rd_we), 32'd0);
    chk("rst_stall", bus.stall_cycles, 32'd0);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table: single instructions with no destination writes.
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      dst(5'd0, 1'b0);
      src(vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, vecs[i].a, vecs[i].b);
      bus.fwd_busy = vecs[i].busy;
      bus.fwd_ok   = vecs[i].ok;
      bus.fwd_rd   = vecs[i].frd;
      bus.fwd_data = fdat;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      if (!vecs[i].exp_rdy) stall_exp++;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.issue_valid), 32'(vecs[i].exp_rdy));
      if (vecs[i].exp_rdy) begin
        chk($sformatf("vec%0d_src1", i), bus.issue_src1, vecs[i].exp1);
        chk($sformatf("vec%0d_src2", i), bus.issue_src2, vecs[i].exp2);
      end
    end
    chk("table_stall", bus.stall_cycles, 32'(stall_exp));

    // x5 <- x1 + x2, then forwarded consumer of x5.
    idle();
    bus.in_valid = 1'b1;
    dst(5'd5, 1'b1);
    src(5'd1, 1'b1, 5'd2, 1'b1, 32'h1000, 32'h2000);
    #1;
    chk("w5_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("w5_valid", 32'(bus.issue_valid), 32'd1);
    chk("w5_rd", 32'(bus.issue_rd), 32'd5);
    chk("w5_rd_we", 32'(bus.issue_rd_we), 32'd1);
    chk("w5_src1", bus.issue_src1, 32'h1000);
    chk("w5_src2", bus.issue_src2, 32'h2000);
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    dst(5'd0, 1'b0);
    src(5'd5, 1'b1, 5'd0, 1'b0, 32'hBAD, 32'h0);
    #1;
    chk("c5_nofwd_ready", 32'(bus.in_ready), 32'd0);
    stall_exp++;
    tick();
    bus.fwd_busy = 3'b001;
    bus.fwd_ok   = 3'b001;
    bus.fwd_rd   = {5'd0, 5'd0, 5'd5};
    bus.fwd_data = {64'd0, 32'h0000_DEAD};
    #1;
    chk("c5_fwd_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("c5_fwd_valid", 32'(bus.issue_valid), 32'd1);
    chk("c5_fwd_src1", bus.issue_src1, 32'h0000_DEAD);
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b1;
    src(5'd5, 1'b1, 5'd0, 1'b0, 32'h5555, 32'h0);
    #1;
    chk("c5_retired_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("c5_retired_src1", bus.issue_src1, 32'h5555);

    // Load-use on x7: stall until port 0 data turns ready.
    bus.fwd_busy = 3'b001;
    bus.fwd_ok   = 3'b000;
    bus.fwd_rd   = {5'd0, 5'd0, 5'd7};
    bus.fwd_data = {64'd0, 32'h77};
    src(5'd7, 1'b1, 5'd0, 1'b0, 32'hBAD, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("lu_stall%0d_ready", k), 32'(bus.in_ready), 32'd0);
      stall_exp++;
      tick();
    end
    bus.fwd_ok = 3'b001;
    #1;
    chk("lu_ok_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("lu_src1", bus.issue_src1, 32'h77);
    chk("lu_stall_count", bus.stall_cycles, 32'(stall_exp));

    // Three writers of x9 saturate the counter; x0 readers never stall.
    idle();
    bus.in_valid = 1'b1;
    dst(5'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("w9_%0d_ready", k), 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    dst(5'd0, 1'b0);
    src(5'd0, 1'b1, 5'd0, 1'b1, 32'h1234, 32'h5678);
    #1;
    chk("x0_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("x0_src1", bus.issue_src1, 32'd0);
    chk("x0_src2", bus.issue_src2, 32'd0);
    src(5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    dst(5'd9, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("waw_%0d_ready", k), 32'(bus.in_ready), 32'd0);
      stall_exp++;
      tick();
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    #1;
    chk("waw_wb_ready", 32'(bus.in_ready), 32'd0);
    stall_exp++;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("waw_after_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("waw_issue_rd", 32'(bus.issue_rd), 32'd9);
    bus.in_valid = 1'b0;
    tick();

    // x4: an issue and a writeback in the same cycle cancel out.
    idle();
    bus.in_valid = 1'b1;
    dst(5'd4, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    #1;
    chk("w4b_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    tick();
    bus.wb_valid = 1'b0;
    dst(5'd0, 1'b0);
    src(5'd4, 1'b1, 5'd0, 1'b0, 32'h4444, 32'd0);
    #1;
    chk("x4_still_busy", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("x4_free_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("x4_regfile_src1", bus.issue_src1, 32'h4444);

    // Backpressure holds the issue register; flush kills it uncounted.
    bus.in_valid = 1'b0;
    tick();
    bus.issue_ready = 1'b0;
    bus.in_valid    = 1'b1;
    dst(5'd10, 1'b1);
    src(5'd1, 1'b1, 5'd0, 1'b0, 32'hA1, 32'd0);
    #1;
    chk("w10_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("w10_valid", 32'(bus.issue_valid), 32'd1);
    chk("w10_src1", bus.issue_src1, 32'hA1);
    dst(5'd0, 1'b0);
    src(5'd1, 1'b1, 5'd0, 1'b0, 32'hB2, 32'd0);
    #1;
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("hold_valid", 32'(bus.issue_valid), 32'd1);
    chk("hold_src1", bus.issue_src1, 32'hA1);
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(bus.issue_valid), 32'd0);
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b1;
    src(5'd10, 1'b1, 5'd0, 1'b0, 32'hC3, 32'd0);
    #1;
    chk("x10_uncounted_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("x10_src1", bus.issue_src1, 32'hC3);
    chk("final_stall", bus.stall_cycles, 32'(stall_exp));

    // Reset in the middle of traffic discards in-flight counts.
    idle();
    bus.in_valid = 1'b1;
    dst(5'd11, 1'b1);
    tick();
    dst(5'd0, 1'b0);
    src(5'd11, 1'b1, 5'd0, 1'b0, 32'hE1, 32'd0);
    tick();
    #1;
    chk("x11_busy", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("mid_rst_stall", bus.stall_cycles, 32'd0);
    #1;
    chk("mid_rst_x11_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
